// File: rtl/mem_burst_master.sv
// mem_burst_master
//   Master side of the memory req/ack interface. Accepts one burst command
//   (base address, beat count, direction) and runs one req/ack transaction per
//   beat at incrementing addresses. Write beats are pulled from a valid/ready
//   stream and read beats are pushed onto one.
//
// Ports
//   clk, reset_n                 clock (posedge) and async active-low reset
//   cmd_valid/cmd_ready          burst command handshake
//   cmd_write, cmd_addr, cmd_len burst direction, first address, beat count
//   wr_valid/wr_ready, wr_data   write beat stream into the block
//   rd_valid/rd_ready, rd_data   read beat stream out of the block
//   done, error                  end-of-burst pulse; error marks a timeout abort
//   mem_req, mem_ack, mem_w_en,
//   mem_addr, mem_data           memory interface (mem_data shared, tri-stated)
module mem_burst_master #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int REQ_DIST   = 4,   // >= 2
    parameter int TIMEOUT    = 8    // >= 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  error,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_REQ, S_WAIT_ACK, S_GAP, S_FINISH
    } state_t;

    localparam int GAP_W = $clog2(REQ_DIST);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    // The req spacing counter is loaded in REQ; the cycle req drops counts as
    // the first gap cycle, so REQ may be re-entered once it reaches zero.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(REQ_DIST - 2);
    // WAIT_ACK is open for TIMEOUT cycles, the last one being to_cnt == 0.
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 1);

    state_t                  state, state_nx;
    logic                    out_en;      // keeps cmd_ready low until the first clock after reset
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [LEN_WIDTH-1:0]    beats_left;
    logic                    is_write;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic                    beat_full;
    logic [GAP_W-1:0]        gap_cnt;
    logic [TO_W-1:0]         to_cnt;
    logic                    beat_avail;
    logic                    drive_bus;

    // A write beat can go out once it is latched or offered this cycle; a read
    // beat only once the output register is free, so read data is never overwritten.
    assign beat_avail = is_write ? (beat_full | wr_valid) : !rd_valid;

    assign drive_bus = is_write && (state == S_REQ || state == S_WAIT_ACK);
    assign mem_w_en  = drive_bus;
    assign mem_data  = drive_bus ? beat_data : {DATA_WIDTH{1'bz}};
    assign mem_addr  = cur_addr;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_req   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = out_en;
                if (cmd_valid && out_en)
                    state_nx = (cmd_len == '0) ? S_FINISH : S_FETCH;
            end
            S_FETCH: begin
                wr_ready = is_write && !beat_full && wr_valid;
                if (beat_avail && gap_cnt == '0)
                    state_nx = S_REQ;
            end
            S_REQ: begin
                mem_req  = 1'b1;
                state_nx = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (mem_ack)
                    state_nx = (beats_left == LEN_WIDTH'(1)) ? S_FINISH : S_GAP;
                else if (to_cnt == '0)
                    state_nx = S_FINISH;
            end
            S_GAP:    state_nx = S_FETCH;
            S_FINISH: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            out_en     <= 1'b0;
            cur_addr   <= '0;
            beats_left <= '0;
            is_write   <= 1'b0;
            beat_data  <= '0;
            beat_full  <= 1'b0;
            gap_cnt    <= '0;
            to_cnt     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            error      <= 1'b0;
        end else begin
            state  <= state_nx;
            out_en <= 1'b1;

            if (rd_valid && rd_ready)
                rd_valid <= 1'b0;

            // Free-running gap countdown; it overlaps FETCH so the later of
            // "beat ready" and "gap expired" decides when REQ happens.
            if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);

            case (state)
                S_IDLE: begin
                    if (cmd_valid && out_en) begin
                        cur_addr   <= cmd_addr;
                        beats_left <= cmd_len;
                        is_write   <= cmd_write;
                        error      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (wr_ready) begin
                        beat_data <= wr_data;
                        beat_full <= 1'b1;
                    end
                end
                S_REQ: begin
                    beat_full <= 1'b0;
                    gap_cnt   <= GAP_LOAD;
                    to_cnt    <= TO_LOAD;
                end
                S_WAIT_ACK: begin
                    if (mem_ack) begin
                        cur_addr   <= cur_addr + ADDR_WIDTH'(1);
                        beats_left <= beats_left - LEN_WIDTH'(1);
                        if (!is_write) begin
                            rd_data  <= mem_data;
                            rd_valid <= 1'b1;
                        end
                    end else if (to_cnt == '0) begin
                        error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
